handshake_cdc: RTL and testbench

Lossless single-word clock-domain crossing for register writebacks and control words between the RoCE stack wrapper domains. Unlike the overwrite-style crossing, every accepted word is delivered exactly once, in order. A two-phase toggle request/acknowledge pair crosses the domains through bit synchronizers. Data is held in a source-domain register until the destination acknowledges capture, so the source side exerts back-pressure through in_ready_o.

---
 rtl/cdc_pkg.sv | 21 ++
 rtl/cdc_sync_bit.sv | 32 +++
 rtl/handshake_cdc.sv | 133 +++++++++++++
 tb/tb_handshake_cdc.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle-handshake clock-domain crossing.
//   src_state_t : source-side FSM states (in_clk_i domain)
//   dst_state_t : destination-side FSM states (out_clk_i domain)
//   *_DEF       : default parameter values used by the crossing blocks
package cdc_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DATA_WIDTH_DEF  = 40;

  typedef enum logic [1:0] {
    SRC_INIT,
    SRC_IDLE,
    SRC_WAIT_ACK
  } src_state_t;

  typedef enum logic {
    DST_IDLE,
    DST_VALID
  } dst_state_t;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer.
//   clk_i  : destination clock
//   rstn_i : destination reset, asynchronous, active-low (chain clears to 0)
//   d_i    : asynchronous input bit
//   q_o    : synchronized output, SYNC_STAGES clk_i edges of latency
// SYNC_STAGES must be at least 2.
module cdc_sync_bit
  import cdc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the previous-edge value of its neighbour.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/handshake_cdc.sv
// Lossless single-word crossing using a two-phase req/ack toggle handshake.
// Source side (in_clk_i):
//   in_valid_i / in_ready_o / in_data_i : word input, ready is state-decoded
//   busy_o                              : word in flight, awaiting acknowledge
// Destination side (out_clk_i):
//   out_valid_o / out_ready_i / out_data_o : word output, valid is state-decoded
// data_src_q is held stable from the req toggle until ack returns, so it is
// sampled directly in out_clk_i; constrain it as a max-delay path of at most
// one out_clk_i period.
module handshake_cdc
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  in_clk_i,
  input  logic                  in_rstn_i,
  input  logic                  out_clk_i,
  input  logic                  out_rstn_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  busy_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o
);

  // ---------------------------------------------------------------- source
  src_state_t            src_state_q, src_state_d;
  logic                  req_q;
  logic                  ack_sync;
  logic [DATA_WIDTH-1:0] data_src_q;
  logic                  src_accept;

  assign src_accept = (src_state_q == SRC_IDLE) && in_valid_i;

  always_ff @(posedge in_clk_i or negedge in_rstn_i) begin
    if (!in_rstn_i) begin
      src_state_q <= SRC_INIT;
    end else begin
      src_state_q <= src_state_d;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    src_state_d = src_state_q;
    unique case (src_state_q)
      SRC_INIT:     src_state_d = SRC_IDLE;
      SRC_IDLE:     if (src_accept) src_state_d = SRC_WAIT_ACK;
      SRC_WAIT_ACK: if (ack_sync == req_q) src_state_d = SRC_IDLE;
      default:      src_state_d = SRC_INIT;
    endcase
  end

  always_comb begin
    in_ready_o = (src_state_q == SRC_IDLE);
    busy_o     = (src_state_q == SRC_WAIT_ACK);
  end

  always_ff @(posedge in_clk_i or negedge in_rstn_i) begin
    if (!in_rstn_i) begin
      req_q      <= 1'b0;
      data_src_q <= '0;
    end else if (src_accept) begin
      req_q      <= ~req_q;
      data_src_q <= in_data_i;
    end
  end

  // ------------------------------------------------------------- crossings
  logic req_sync;
  logic ack_q;

  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk_i  (out_clk_i),
    .rstn_i (out_rstn_i),
    .d_i    (req_q),
    .q_o    (req_sync)
  );

  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk_i  (in_clk_i),
    .rstn_i (in_rstn_i),
    .d_i    (ack_q),
    .q_o    (ack_sync)
  );

  // ----------------------------------------------------------- destination
  dst_state_t            dst_state_q, dst_state_d;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  dst_load;

  // A pending request is only taken in IDLE, so a word launched while the
  // previous one is still held in VALID waits in data_src_q.
  assign dst_load = (dst_state_q == DST_IDLE) && (req_sync ^ ack_q);

  always_ff @(posedge out_clk_i or negedge out_rstn_i) begin
    if (!out_rstn_i) begin
      dst_state_q <= DST_IDLE;
    end else begin
      dst_state_q <= dst_state_d;
    end
  end

  always_comb begin
    dst_state_d = dst_state_q;
    unique case (dst_state_q)
      DST_IDLE:  if (dst_load) dst_state_d = DST_VALID;
      DST_VALID: if (out_ready_i) dst_state_d = DST_IDLE;
      default:   dst_state_d = DST_IDLE;
    endcase
  end

  always_comb begin
    out_valid_o = (dst_state_q == DST_VALID);
    out_data_o  = data_out_q;
  end

  // ack toggles at capture, releasing the source before consumption.
  always_ff @(posedge out_clk_i or negedge out_rstn_i) begin
    if (!out_rstn_i) begin
      ack_q      <= 1'b0;
      data_out_q <= '0;
    end else if (dst_load) begin
      ack_q      <= ~ack_q;
      data_out_q <= data_src_q;
    end
  end

endmodule

// File: tb/tb_handshake_cdc.sv
`timescale 1ns/1ps
module tb_handshake_cdc;

  localparam int DW = 40;

  logic          in_clk = 1'b0;
  logic          out_clk = 1'b0;
  logic          in_rstn = 1'b0;
  logic          out_rstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          busy;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;

  int in_half  = 5;
  int out_half = 5;
  int rdy_mode = 0;           // 0: always ready, 1: random, 2: held low

  int checks    = 0;
  int errors    = 0;
  int delivered = 0;
  int in_cyc    = 0;
  int out_cyc   = 0;

  logic [DW-1:0] sb[$];

  handshake_cdc #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .in_clk_i    (in_clk),
    .in_rstn_i   (in_rstn),
    .out_clk_i   (out_clk),
    .out_rstn_i  (out_rstn),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .busy_o      (busy),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
  );

  initial forever #(in_half)  in_clk  = ~in_clk;
  initial forever #(out_half) out_clk = ~out_clk;

  always @(posedge in_clk)  in_cyc++;
  always @(posedge out_clk) out_cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer-side ready driver.
  always begin
    @(posedge out_clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: a handshake seen mid-cycle completes on the next out_clk edge.
  always @(negedge out_clk) begin
    if (out_rstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word got %0h expected none", out_data);
      end else begin
        check("out_data", 64'(out_data), 64'(sb.pop_front()));
      end
      delivered++;
    end
  end

  task automatic send(input logic [DW-1:0] d, input bit hold);
    bit ok;
    ok       = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge in_clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) sb.push_back(d);
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout got ready=0 expected ready=1");
    end
    @(posedge in_clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20000 && sb.size() != 0; i++) @(posedge in_clk);
    repeat (10) @(posedge in_clk);
    check(name, 64'(sb.size()), 64'd0);
  endtask

  // Joint reset, asserted asynchronously, released on an in_clk falling edge.
  task automatic joint_reset(input string name);
    in_rstn  = 1'b0;
    out_rstn = 1'b0;
    in_valid = 1'b0;
    #1;
    check({name, "_ready"}, 64'(in_ready),  64'd0);
    check({name, "_busy"},  64'(busy),      64'd0);
    check({name, "_valid"}, 64'(out_valid), 64'd0);
    check({name, "_data"},  64'(out_data),  64'd0);
    sb.delete();
    repeat (3) @(posedge in_clk);
    @(negedge in_clk);
    in_rstn  = 1'b1;
    out_rstn = 1'b1;
  endtask

  initial begin
    int lat;
    int ret;
    int icyc0;
    int ocyc0;
    bit seen;
    logic [DW-1:0] w;

    // ---------------- reset and first-edge behaviour
    in_valid = 1'b1;
    in_data  = 40'hDE_AD00_BEEF;
    #1;
    check("rst_ready", 64'(in_ready),  64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    repeat (3) @(posedge in_clk);
    @(negedge in_clk);
    in_rstn  = 1'b1;
    out_rstn = 1'b1;
    #1;
    check("init_ready_low", 64'(in_ready), 64'd0);
    @(posedge in_clk);
    #1;
    check("init_ready_high", 64'(in_ready), 64'd1);
    check("init_not_taken",  64'(busy),     64'd0);
    in_valid = 1'b0;
    repeat (20) @(posedge in_clk);
    check("no_phantom", 64'(delivered), 64'd0);

    // ---------------- single word, equal clocks
    send(40'hAB_1234_5678, 1'b0);
    icyc0 = in_cyc;
    ocyc0 = out_cyc;
    seen  = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge out_clk);
      seen = out_valid;
    end
    lat = out_cyc - ocyc0;
    check("valid_latency", 64'(lat), 64'd3);
    @(negedge out_clk);
    check("valid_pulse", 64'(out_valid), 64'd0);
    seen = 1'b0;
    while (!seen && (in_cyc - icyc0) < 12) begin
      @(posedge in_clk);
      #1;
      seen = in_ready;
    end
    ret = in_cyc - icyc0;
    check("ready_return", 64'(ret), 64'd6);
    drain("single_drained");
    check("single_count", 64'(delivered), 64'd1);

    // ---------------- burst of 16, valid held
    delivered = 0;
    for (int i = 0; i < 16; i++) begin
      send(40'(i), 1'b1);
      if (i == 3) check("burst_ready_low", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    drain("burst_drained");
    check("burst_count", 64'(delivered), 64'd16);

    // ---------------- consumer stall: word 0 held, word 1 parked
    delivered = 0;
    rdy_mode  = 2;
    repeat (2) @(posedge out_clk);
    send(40'h100, 1'b0);
    send(40'h101, 1'b0);
    repeat (50) @(posedge out_clk);
    @(negedge out_clk);
    check("stall_valid", 64'(out_valid), 64'd1);
    check("stall_data",  64'(out_data),  64'h100);
    check("stall_busy",  64'(busy),      64'd1);
    rdy_mode = 0;
    drain("stall_drained");
    check("stall_count", 64'(delivered), 64'd2);

    // ---------------- random traffic at 1:3 and 3:1
    for (int r = 0; r < 2; r++) begin
      in_half  = (r == 0) ? 2 : 6;
      out_half = (r == 0) ? 6 : 2;
      repeat (5) @(posedge out_clk);
      delivered = 0;
      rdy_mode  = 1;
      for (int i = 0; i < 500; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge in_clk);
        w = {8'($urandom), 32'($urandom)};
        send(w, 1'b0);
      end
      drain(r == 0 ? "ratio_1_3_drained" : "ratio_3_1_drained");
      check(r == 0 ? "ratio_1_3_count" : "ratio_3_1_count", 64'(delivered), 64'd500);
      rdy_mode = 0;
    end
    in_half  = 5;
    out_half = 5;
    repeat (5) @(posedge in_clk);

    // ---------------- joint reset during WAIT_ACK
    send(40'h55_0000_0001, 1'b0);
    check("wait_ack_busy", 64'(busy), 64'd1);
    joint_reset("rst_wait");
    delivered = 0;
    repeat (20) @(posedge in_clk);
    check("rst_wait_no_phantom", 64'(delivered), 64'd0);
    send(40'h55_0000_0002, 1'b0);
    drain("rst_wait_next");
    check("rst_wait_count", 64'(delivered), 64'd1);

    // ---------------- joint reset during VALID
    rdy_mode = 2;
    repeat (2) @(posedge out_clk);
    send(40'h66_0000_0003, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge out_clk);
      seen = out_valid;
    end
    check("valid_before_rst", 64'(out_data), 64'h66_0000_0003);
    joint_reset("rst_valid");
    rdy_mode  = 0;
    delivered = 0;
    repeat (20) @(posedge in_clk);
    check("rst_valid_no_phantom", 64'(delivered), 64'd0);
    send(40'h66_0000_0004, 1'b0);
    drain("rst_valid_next");
    check("rst_valid_count", 64'(delivered), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
